// File: rtl/seq_detect_param_if.sv
// Serial-detector port bundle: data/config inputs and match outputs.
interface seq_detect_param_if #(
  parameter int SEQ_LEN = 8,
  parameter int CNT_W   = 16
);
  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [SEQ_LEN-1:0] cfg_pattern;
  logic [SEQ_LEN-1:0] cfg_mask;
  logic               overlap_en;
  logic               cnt_clr;
  logic               dout;
  logic               armed;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cfg_mask, overlap_en, cnt_clr,
    input  dout, armed, match_count
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cfg_mask, overlap_en, cnt_clr,
    output dout, armed, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with care-mask, overlap control
// and a saturating match counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   S_FILL  | fewer than SEQ_LEN bits accepted, no match possible
//   S_ARMED | history full, every accepted bit is compared
module seq_detect_param #(
  parameter int                 SEQ_LEN     = 8,
  parameter logic [SEQ_LEN-1:0] RST_PATTERN = SEQ_LEN'(8'b0110_1000),
  parameter logic [SEQ_LEN-1:0] RST_MASK    = '1,
  parameter int                 CNT_W       = 16
) (
  input logic                clk,
  input logic                reset,
  seq_detect_param_if.slave  bus
);

  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

  typedef enum logic {S_FILL, S_ARMED} state_e;

  state_e               state_q, state_d;
  // The oldest of the SEQ_LEN window bits is shifted out before it is ever
  // compared, so only SEQ_LEN-1 past bits need storage; din supplies the rest.
  logic [SEQ_LEN-2:0]   hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [SEQ_LEN-1:0]   pat_q, pat_d;
  logic [SEQ_LEN-1:0]   mask_q, mask_d;
  logic                 dout_q, dout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 match;
  logic [SEQ_LEN-1:0]   window;
  logic [FILL_W-1:0]    fill_inc;

  // Next-state: config load, bit acceptance, match evaluation, counter
  always_comb begin
    accept   = bus.din_valid & ~bus.cfg_load;
    window   = {hist_q, bus.din};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match    = accept && (fill_inc == FILL_FULL) &&
               (((window ^ pat_q) & mask_q) == '0);

    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    dout_d  = 1'b0;
    cnt_d   = cnt_q;

    if (bus.cfg_load) begin
      pat_d   = bus.cfg_pattern;
      mask_d  = bus.cfg_mask;
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (accept) begin
      hist_d  = window[SEQ_LEN-2:0];
      fill_d  = fill_inc;
      state_d = (fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
      if (match) begin
        dout_d = 1'b1;
        // Non-overlapping: demand a completely fresh window before the next hit
        if (!bus.overlap_en) begin
          fill_d  = '0;
          state_d = S_FILL;
        end
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      mask_q  <= RST_MASK;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.armed       = (state_q == S_ARMED);
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a CNT_W=2
// instance for counter saturation.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  seq_detect_param_if #(.SEQ_LEN(8), .CNT_W(16)) bus1 ();
  seq_detect_param_if #(.SEQ_LEN(8), .CNT_W(2))  bus2 ();

  seq_detect_param #(.SEQ_LEN(8), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  seq_detect_param #(.SEQ_LEN(8), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send n bits MSB first on bus1, checking dout after each accepting edge.
  task automatic send_seq(input string tag, input logic [15:0] bits, input int n,
                          input logic [15:0] exp);
    logic [15:0] b;
    logic [15:0] e;
    b = bits;
    e = exp;
    for (int i = 0; i < n; i++) begin
      bus1.din       = b[n-1-i];
      bus1.din_valid = 1'b1;
      tick();
      chk($sformatf("%s_bit%0d", tag, i + 1), {31'd0, bus1.dout}, {31'd0, e[n-1-i]});
    end
    bus1.din_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [7:0] mask);
    bus1.cfg_pattern = pat;
    bus1.cfg_mask    = mask;
    bus1.cfg_load    = 1'b1;
    tick();
    bus1.cfg_load    = 1'b0;
    chk("cfg_armed", {31'd0, bus1.armed}, 32'd0);
  endtask

  task automatic clr_cnt();
    bus1.cnt_clr = 1'b1;
    tick();
    bus1.cnt_clr = 1'b0;
    chk("cnt_clr", {16'd0, bus1.match_count}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus1.din_valid   = 1'b0;
    bus1.din         = 1'b0;
    bus1.cfg_load    = 1'b0;
    bus1.cfg_pattern = '0;
    bus1.cfg_mask    = '0;
    bus1.overlap_en  = 1'b1;
    bus1.cnt_clr     = 1'b0;
    bus2.din_valid   = 1'b0;
    bus2.din         = 1'b0;
    bus2.cfg_load    = 1'b0;
    bus2.cfg_pattern = '0;
    bus2.cfg_mask    = '0;
    bus2.overlap_en  = 1'b1;
    bus2.cnt_clr     = 1'b0;

    // Reset state and basic 0x68 detection
    do_reset();
    chk("rst_dout",  {31'd0, bus1.dout},  32'd0);
    chk("rst_armed", {31'd0, bus1.armed}, 32'd0);
    chk("rst_count", {16'd0, bus1.match_count}, 32'd0);
    send_seq("b68", 16'h0068, 8, 16'h0001);
    chk("b68_armed", {31'd0, bus1.armed}, 32'd1);
    chk("b68_count", {16'd0, bus1.match_count}, 32'd1);
    tick();
    chk("b68_pulse_end", {31'd0, bus1.dout}, 32'd0);

    // Same stream with a 3-cycle valid gap after bit 4
    do_reset();
    send_seq("gap_a", 16'h0006, 4, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_idle", {31'd0, bus1.dout}, 32'd0);
    end
    chk("gap_armed", {31'd0, bus1.armed}, 32'd0);
    send_seq("gap_b", 16'h0008, 4, 16'h0001);
    chk("gap_count", {16'd0, bus1.match_count}, 32'd1);

    // 0xAA, overlapping: hits after bits 8, 10, 12
    bus1.overlap_en = 1'b1;
    load_cfg(8'hAA, 8'hFF);
    clr_cnt();
    send_seq("aa_ov", 16'h0AAA, 12, 16'h0015);
    chk("aa_ov_count", {16'd0, bus1.match_count}, 32'd3);

    // 0xAA, non-overlapping: only after bit 8
    bus1.overlap_en = 1'b0;
    load_cfg(8'hAA, 8'hFF);
    clr_cnt();
    send_seq("aa_nov", 16'h0AAA, 12, 16'h0010);
    chk("aa_nov_count", {16'd0, bus1.match_count}, 32'd1);
    chk("aa_nov_armed", {31'd0, bus1.armed}, 32'd0);

    // Care-mask: high nibble only
    bus1.overlap_en = 1'b1;
    load_cfg(8'h60, 8'hF0);
    clr_cnt();
    send_seq("mask_hit", 16'h006B, 8, 16'h0001);
    load_cfg(8'h60, 8'hF0);
    send_seq("mask_miss", 16'h0070, 8, 16'h0000);
    chk("mask_count", {16'd0, bus1.match_count}, 32'd1);

    // All-zero mask, non-overlapping: one hit per 8 bits
    bus1.overlap_en = 1'b0;
    load_cfg(8'h00, 8'h00);
    clr_cnt();
    send_seq("mask0", 16'h3C5A, 16, 16'h0101);
    chk("mask0_count", {16'd0, bus1.match_count}, 32'd2);

    // Reset mid-sequence discards the prefix and restores 0x68/0xFF
    bus1.overlap_en = 1'b1;
    send_seq("pre_rst", 16'h000D, 5, 16'h0000);
    do_reset();
    chk("mid_rst_armed", {31'd0, bus1.armed}, 32'd0);
    chk("mid_rst_count", {16'd0, bus1.match_count}, 32'd0);
    send_seq("post_rst", 16'h0068, 8, 16'h0001);

    // cfg_load with din_valid drops that bit and empties the history
    send_seq("pre_load", 16'h0003, 3, 16'h0000);
    bus1.cfg_pattern = 8'h68;
    bus1.cfg_mask    = 8'hFF;
    bus1.cfg_load    = 1'b1;
    bus1.din_valid   = 1'b1;
    bus1.din         = 1'b1;
    tick();
    bus1.cfg_load    = 1'b0;
    bus1.din_valid   = 1'b0;
    chk("ld_drop_dout",  {31'd0, bus1.dout},  32'd0);
    chk("ld_drop_armed", {31'd0, bus1.armed}, 32'd0);
    send_seq("ld_a", 16'h0034, 7, 16'h0000);
    chk("ld_fill7_armed", {31'd0, bus1.armed}, 32'd0);
    send_seq("ld_b", 16'h0000, 1, 16'h0001);
    chk("ld_count", {16'd0, bus1.match_count}, 32'd2);

    // CNT_W=2 instance: saturation and cnt_clr priority
    bus2.cfg_pattern = '0;
    bus2.cfg_mask    = '0;
    bus2.cfg_load    = 1'b1;
    tick();
    bus2.cfg_load    = 1'b0;
    chk("sat_cnt0", {30'd0, bus2.match_count}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus2.din       = i[0];
      bus2.din_valid = 1'b1;
      tick();
    end
    chk("sat_dout1", {31'd0, bus2.dout}, 32'd1);
    chk("sat_cnt1",  {30'd0, bus2.match_count}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus2.din = 1'b1;
      tick();
      chk($sformatf("sat_cnt_step%0d", i), {30'd0, bus2.match_count},
          (i == 0) ? 32'd2 : 32'd3);
    end
    bus2.cnt_clr = 1'b1;
    tick();
    bus2.cnt_clr   = 1'b0;
    bus2.din_valid = 1'b0;
    chk("clr_win_cnt",  {30'd0, bus2.match_count}, 32'd0);
    chk("clr_win_dout", {31'd0, bus2.dout}, 32'd1);
    tick();
    chk("clr_idle_dout", {31'd0, bus2.dout}, 32'd0);
    chk("clr_idle_cnt",  {30'd0, bus2.match_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector. Accepts one bit per qualified clock and pulses dout when the last SEQ_LEN accepted bits equal a programmable pattern under a programmable care-mask.
- Successor to the fixed 8-bit BCD-68 Moore detector. Adds runtime pattern/mask load, selectable overlapping or non-overlapping detection, input qualification, and a saturating match counter.
- Sits on the serial receive path ahead of the frame/status logic.

Parameters:
- SEQ_LEN, 8, pattern length in bits (2..32).
- RST_PATTERN, 8'b0110_1000, pattern loaded at reset (BCD "68"). The first received bit is the pattern MSB.
- RST_MASK, all ones, care-mask loaded at reset (1 = compare bit, 0 = don't care).
- CNT_W, 16, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- din_valid  input  1  din is accepted on this clock edge only when high
- din  input  1  serial data bit
- cfg_load  input  1  load cfg_pattern/cfg_mask on this edge
- cfg_pattern  input  SEQ_LEN  new pattern (MSB = first bit)
- cfg_mask  input  SEQ_LEN  new care-mask
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  clear match_count
- dout  output  1  one-cycle match pulse, registered
- armed  output  1  history holds SEQ_LEN valid bits
- match_count  output  CNT_W  saturating count of matches

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). All inputs are sampled on the rising edge of clk.
- Reset values:
  - history = 0, fill = 0
  - pattern = RST_PATTERN, mask = RST_MASK
  - dout = 0, armed = 0, match_count = 0
- Reset has priority over every other input. Reset mid-sequence discards all partial history.
- History shift register, SEQ_LEN bits. On an accepted bit (din_valid=1, cfg_load=0): history <= {history[SEQ_LEN-2:0], din}; fill <= fill+1, saturating at SEQ_LEN.
- When din_valid=0, history, fill and state hold; dout is 0 the next cycle.
- State machine, two states:
  - FILL: fill < SEQ_LEN. armed = 0. No match is possible.
  - ARMED: fill == SEQ_LEN. armed = 1.
  - FILL -> ARMED on the accepted bit that makes fill reach SEQ_LEN. That same bit is compared.
- Match condition, evaluated on an accepted bit: the post-shift history satisfies ((history_next ^ pattern) & mask) == 0, and the post-shift fill == SEQ_LEN.
- Latency: dout = 1 in the cycle immediately after the edge that accepted the final matching bit, for exactly one cycle. Consecutive matches produce back-to-back pulses.
- overlap_en = 1: after a match the history is retained. A 1-bit-shifted overlapping pattern can match on the next accepted bit.
- overlap_en = 0: on a match, fill <= 0 and the state returns to FILL. The next match requires SEQ_LEN fresh accepted bits.
- overlap_en is sampled on each edge. Changing it does not alter history.
- cfg_load = 1:
  - pattern <= cfg_pattern, mask <= cfg_mask, history <= 0, fill <= 0, state -> FILL.
  - A simultaneous din_valid bit is discarded and no match is evaluated.
  - match_count is unaffected.
- mask == 0: every accepted bit in ARMED matches. In non-overlap mode this yields one match per SEQ_LEN accepted bits.
- match_count:
  - Increments by 1 on each match edge (the same edge that sets dout next cycle).
  - Saturates at 2^CNT_W-1.
  - cnt_clr forces it to 0. cnt_clr wins over a simultaneous match, so the result is 0.
- No X propagation: dout and armed are pure registered outputs with no combinational path from inputs.

Test Plan:
- Reset, then stream 0,1,1,0,1,0,0,0 with din_valid=1 every cycle -> armed rises after the 8th edge. dout=1 for exactly one cycle after the 8th edge. match_count=1.
- Same stream with din_valid=0 inserted for 3 cycles after the 4th bit -> identical single match. dout is delayed by 3 cycles; no spurious pulses.
- cfg_load cfg_pattern=8'hAA, mask=8'hFF. Stream 1,0 repeated 6 times (12 bits):
  - overlap_en=1 -> matches after bits 8, 10 and 12; count=3.
  - overlap_en=0 -> match only after bit 8; count=1.
- mask=8'hF0, pattern=8'h60, stream 0110_1011 -> match (low nibble ignored). Stream 0111_0000 -> no match.
- Assert reset after 5 bits of 0x68, then send the 8 bits of 0x68 -> single match after the 8th post-reset bit. No match from the pre-reset prefix. cfg_load asserted together with din_valid -> that bit is dropped and fill=0.
- CNT_W=2: drive 5 matches -> match_count saturates at 3. Assert cnt_clr on the same edge as a match -> match_count=0 and dout still pulses.
